vram_fetch: RTL and testbench

- Sits between the Vector-06C video block / CPU bus and the SDRAM controller.
- Takes the video block's 13-bit word fetch strobes and the CPU's byte writes into VRAM, and serialises both onto one SDRAM request/acknowledge port.
- Video reads have priority. CPU writes are posted through a small FIFO so the CPU never waits on SDRAM.
- Returns the 32-bit plane word (4 planes x 8 bits) to the video shifter.

---
 rtl/vram_fetch_if.sv | 20 ++
 rtl/vram_fetch.sv | 230 +++++++++++++++++++++++
 tb/tb_vram_fetch.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_fetch_if.sv
// SDRAM request/acknowledge port shared by vram_fetch (master) and the SDRAM controller (slave).
interface vram_fetch_if;
  logic        sdr_req;
  logic        sdr_we;
  logic [24:0] sdr_addr;
  logic [3:0]  sdr_be;
  logic [31:0] sdr_wdata;
  logic        sdr_ack;
  logic [31:0] sdr_rdata;

  modport master (
    output sdr_req, sdr_we, sdr_addr, sdr_be, sdr_wdata,
    input  sdr_ack, sdr_rdata
  );

  modport slave (
    input  sdr_req, sdr_we, sdr_addr, sdr_be, sdr_wdata,
    output sdr_ack, sdr_rdata
  );
endinterface

// File: rtl/vram_fetch.sv
// Serialises video word fetches and posted CPU VRAM byte writes onto one SDRAM port.
// Optional macro VRAM_WRMERGE_EN merges still-queued CPU writes into returned video data.
module vram_fetch #(
  parameter logic [24:0] VRAM_BASE   = 25'h0,
  parameter int          WFIFO_DEPTH = 4
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         vid_rd,
  input  logic [12:0]  vid_addr,
  output logic [31:0]  vid_data,
  output logic         vid_valid,
  input  logic         cpu_we,
  input  logic [15:0]  cpu_addr,
  input  logic [7:0]   cpu_din,
  output logic         cpu_full,
  vram_fetch_if.master sdr,
  output logic [1:0]   ovf
);

  localparam int            PW      = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(WFIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [12:0]   fifo_word_q [WFIFO_DEPTH];
  logic [12:0]   fifo_word_d [WFIFO_DEPTH];
  logic [1:0]    fifo_lane_q [WFIFO_DEPTH];
  logic [1:0]    fifo_lane_d [WFIFO_DEPTH];
  logic [7:0]    fifo_byte_q [WFIFO_DEPTH];
  logic [7:0]    fifo_byte_d [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic [12:0]   pend_addr_q, pend_addr_d;
  logic          sdr_req_q, sdr_req_d;
  logic          sdr_we_q, sdr_we_d;
  logic [24:0]   sdr_addr_q, sdr_addr_d;
  logic [3:0]    sdr_be_q, sdr_be_d;
  logic [31:0]   sdr_wdata_q, sdr_wdata_d;
  logic [31:0]   vid_data_q, vid_data_d;
  logic          vid_valid_q, vid_valid_d;
  logic [1:0]    ovf_q, ovf_d;
  logic [31:0]   rd_merged;
  logic          wr_hit;
  logic          push;
  logic          pop;
  logic          consume;

`ifdef VRAM_WRMERGE_EN
  logic [12:0]   rd_word_q, rd_word_d;

  // Queued writes to the word being read overlay their byte lane, oldest first so the newest wins.
  always_comb begin
    logic [PW-1:0] idx;
    rd_merged = sdr.sdr_rdata;
    idx       = rd_ptr_q;
    for (int i = 0; i < WFIFO_DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (fifo_word_q[idx] == rd_word_q)) begin
        rd_merged[{fifo_lane_q[idx], 3'b000} +: 8] = fifo_byte_q[idx];
      end
    end
  end
`else
  assign rd_merged = sdr.sdr_rdata;
`endif

  always_comb begin
    state_d     = state_q;
    fifo_word_d = fifo_word_q;
    fifo_lane_d = fifo_lane_q;
    fifo_byte_d = fifo_byte_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    sdr_req_d   = sdr_req_q;
    sdr_we_d    = sdr_we_q;
    sdr_addr_d  = sdr_addr_q;
    sdr_be_d    = sdr_be_q;
    sdr_wdata_d = sdr_wdata_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    ovf_d       = ovf_q;
`ifdef VRAM_WRMERGE_EN
    rd_word_d   = rd_word_q;
`endif

    wr_hit  = cpu_we & cpu_addr[15];
    pop     = (state_q == ST_WR) & sdr.sdr_ack;
    push    = wr_hit & ((count_q != DEPTH_C) | pop);
    consume = (state_q == ST_IDLE) & pend_q;

    // A pending read handed to the FSM this cycle is not lost, so a new strobe is not an overrun.
    if (consume) begin
      pend_d = 1'b0;
    end
    if (vid_rd) begin
      if (pend_q & ~consume) begin
        ovf_d[0] = 1'b1;
      end
      pend_d      = 1'b1;
      pend_addr_d = vid_addr;
    end

    if (wr_hit & ~push) begin
      ovf_d[1] = 1'b1;
    end
    if (push) begin
      fifo_word_d[wr_ptr_q] = cpu_addr[12:0];
      fifo_lane_d[wr_ptr_q] = cpu_addr[14:13];
      fifo_byte_d[wr_ptr_q] = cpu_din;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d     = ST_RD;
          sdr_req_d   = 1'b1;
          sdr_we_d    = 1'b0;
          sdr_addr_d  = VRAM_BASE | {12'b0, pend_addr_q};
          sdr_be_d    = 4'b0000;
          sdr_wdata_d = 32'h0;
`ifdef VRAM_WRMERGE_EN
          rd_word_d   = pend_addr_q;
`endif
        end else if (count_q != '0) begin
          state_d     = ST_WR;
          sdr_req_d   = 1'b1;
          sdr_we_d    = 1'b1;
          sdr_addr_d  = VRAM_BASE | {12'b0, fifo_word_q[rd_ptr_q]};
          sdr_be_d    = 4'b0001 << fifo_lane_q[rd_ptr_q];
          sdr_wdata_d = {4{fifo_byte_q[rd_ptr_q]}};
        end
      end
      ST_RD: begin
        if (sdr.sdr_ack) begin
          state_d     = ST_IDLE;
          sdr_req_d   = 1'b0;
          vid_data_d  = rd_merged;
          vid_valid_d = 1'b1;
        end
      end
      ST_WR: begin
        if (sdr.sdr_ack) begin
          state_d   = ST_IDLE;
          sdr_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sdr_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      sdr_req_q   <= 1'b0;
      sdr_we_q    <= 1'b0;
      sdr_addr_q  <= '0;
      sdr_be_q    <= '0;
      sdr_wdata_q <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      ovf_q       <= '0;
`ifdef VRAM_WRMERGE_EN
      rd_word_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      sdr_req_q   <= sdr_req_d;
      sdr_we_q    <= sdr_we_d;
      sdr_addr_q  <= sdr_addr_d;
      sdr_be_q    <= sdr_be_d;
      sdr_wdata_q <= sdr_wdata_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      ovf_q       <= ovf_d;
`ifdef VRAM_WRMERGE_EN
      rd_word_q   <= rd_word_d;
`endif
    end
  end

  // Entry storage needs no reset; occupancy is governed entirely by the pointers and count.
  always_ff @(posedge clk_sys) begin
    fifo_word_q <= fifo_word_d;
    fifo_lane_q <= fifo_lane_d;
    fifo_byte_q <= fifo_byte_d;
  end

  assign sdr.sdr_req   = sdr_req_q;
  assign sdr.sdr_we    = sdr_we_q;
  assign sdr.sdr_addr  = sdr_addr_q;
  assign sdr.sdr_be    = sdr_be_q;
  assign sdr.sdr_wdata = sdr_wdata_q;
  assign vid_data      = vid_data_q;
  assign vid_valid     = vid_valid_q;
  assign ovf           = ovf_q;
  assign cpu_full      = (count_q == DEPTH_C);

endmodule

// File: tb/tb_vram_fetch.sv
// Self-checking bench for vram_fetch: directed scenarios, then randomized traffic against a transaction-level model.
// Honours VRAM_WRMERGE_EN when computing expected read data.
module tb_vram_fetch;
  localparam logic [24:0] BASE  = 25'h100000;
  localparam int          DEPTH = 4;
`ifdef VRAM_WRMERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  typedef struct {
    logic [12:0] word;
    logic [1:0]  lane;
    logic [7:0]  data;
  } wentry_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vid_rd;
  logic [12:0] vid_addr;
  logic [31:0] vid_data;
  logic        vid_valid;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_full;
  logic [1:0]  ovf;

  vram_fetch_if sdr_bus();

  vram_fetch #(.VRAM_BASE(BASE), .WFIFO_DEPTH(DEPTH)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vid_rd    (vid_rd),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_full  (cpu_full),
    .sdr       (sdr_bus),
    .ovf       (ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: accepted writes in commit order, the pending video read and sticky flags.
  wentry_t     model_q[$];
  logic        model_pend      = 1'b0;
  logic [12:0] model_pend_addr = '0;
  logic [1:0]  model_ovf       = '0;
  logic [12:0] issued_rd_addr  = '0;
  int          wr_ack_count    = 0;
  int          valid_count     = 0;
  bit          rd_outstanding  = 1'b0;

  // SDRAM slave controls.
  bit          ack_hold   = 1'b0;
  bit          ack_rand   = 1'b0;
  int          ack_delay  = 2;
  logic [31:0] next_rdata = '0;

  // Every comparison lands here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge; strobes are cleared at the following negedge.
  task automatic applyStimulus(input bit rd, input logic [12:0] va, input bit we,
                               input logic [15:0] ca, input logic [7:0] cd);
    vid_rd   = rd;
    vid_addr = va;
    cpu_we   = we;
    cpu_addr = ca;
    cpu_din  = cd;
    @(negedge clk_sys);
    vid_rd = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic wait_any_req(input string tag);
    int n = 0;
    while (sdr_bus.sdr_req !== 1'b1 && n < 60) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(tag, 64'(n < 60), 64'd1);
  endtask

  task automatic wait_read_req(input string tag);
    int n = 0;
    while (!(sdr_bus.sdr_req === 1'b1 && sdr_bus.sdr_we === 1'b0) && n < 60) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(tag, 64'(n < 60), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (vid_valid !== 1'b1 && n < 60) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(tag, 64'(n < 60), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sdr_bus.sdr_req === 1'b1 || model_q.size() != 0 || model_pend || rd_outstanding)
           && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(tag, 64'(n < budget), 64'd1);
  endtask

  function automatic logic [31:0] expect_rd(input logic [31:0] raw, input logic [12:0] w);
    logic [31:0] d = raw;
    foreach (model_q[i]) begin
      if (MERGE_EN && model_q[i].word == w) d[model_q[i].lane*8 +: 8] = model_q[i].data;
    end
    return d;
  endfunction

  // SDRAM slave: acks ack_delay cycles after seeing a request, one-cycle pulse.
  initial begin
    int wait_cnt = 0;
    sdr_bus.sdr_ack   = 1'b0;
    sdr_bus.sdr_rdata = '0;
    forever begin
      @(negedge clk_sys);
      if (sdr_bus.sdr_ack) begin
        sdr_bus.sdr_ack = 1'b0;
        wait_cnt        = 0;
      end else if (sdr_bus.sdr_req === 1'b1 && !ack_hold && !reset) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          sdr_bus.sdr_ack   = 1'b1;
          sdr_bus.sdr_rdata = ack_rand ? $urandom : next_rdata;
          if (ack_rand) ack_delay = $urandom_range(1, 4);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: just after each edge, retire acked transactions, check newly issued requests and update the model.
  initial begin
    logic        prev_req   = 1'b0;
    logic        prev_we    = 1'b0;
    logic [24:0] prev_addr  = '0;
    logic [3:0]  prev_be    = '0;
    logic [31:0] prev_wdata = '0;
    bit          rd_ack_now;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset) begin
        model_q.delete();
        model_pend = 1'b0;
        model_ovf  = '0;
        checkOutput("reset_req",   64'(sdr_bus.sdr_req), 64'd0);
        checkOutput("reset_valid", 64'(vid_valid), 64'd0);
        checkOutput("reset_full",  64'(cpu_full), 64'd0);
        checkOutput("reset_ovf",   64'(ovf), 64'd0);
        checkOutput("reset_data",  64'(vid_data), 64'd0);
      end else begin
        rd_ack_now = 1'b0;
        if (sdr_bus.sdr_ack && prev_req) begin
          if (prev_we) begin
            if (model_q.size() == 0) begin
              checkOutput("wr_unexpected", 64'd1, 64'd0);
            end else begin
              checkOutput("wr_ack_addr", 64'(prev_addr), 64'(BASE | {12'b0, model_q[0].word}));
              checkOutput("wr_ack_be", 64'(prev_be), 64'(4'b0001 << model_q[0].lane));
              checkOutput("wr_ack_wdata", 64'(prev_wdata), 64'({4{model_q[0].data}}));
              void'(model_q.pop_front());
              wr_ack_count++;
            end
          end else begin
            rd_ack_now = 1'b1;
            checkOutput("rd_valid", 64'(vid_valid), 64'd1);
            checkOutput("rd_data", 64'(vid_data), 64'(expect_rd(sdr_bus.sdr_rdata, issued_rd_addr)));
            valid_count++;
            rd_outstanding = 1'b0;
          end
          checkOutput("req_drop", 64'(sdr_bus.sdr_req), 64'd0);
        end
        if (vid_valid && !rd_ack_now) checkOutput("spurious_valid", 64'(vid_valid), 64'd0);

        if (sdr_bus.sdr_req && !prev_req) begin
          if (!sdr_bus.sdr_we) begin
            if (!model_pend) begin
              checkOutput("rd_unexpected", 64'd1, 64'd0);
            end else begin
              checkOutput("rd_addr", 64'(sdr_bus.sdr_addr), 64'(BASE | {12'b0, model_pend_addr}));
              checkOutput("rd_be", 64'(sdr_bus.sdr_be), 64'd0);
              issued_rd_addr = model_pend_addr;
              model_pend     = 1'b0;
            end
          end else begin
            if (model_pend) checkOutput("rd_priority", 64'(sdr_bus.sdr_we), 64'd0);
            if (model_q.size() == 0) checkOutput("wr_issue_empty", 64'd1, 64'd0);
            else checkOutput("wr_issue_addr", 64'(sdr_bus.sdr_addr), 64'(BASE | {12'b0, model_q[0].word}));
          end
        end else if (sdr_bus.sdr_req && prev_req) begin
          checkOutput("req_stable", {sdr_bus.sdr_we, sdr_bus.sdr_addr, sdr_bus.sdr_be, sdr_bus.sdr_wdata},
                      {prev_we, prev_addr, prev_be, prev_wdata});
        end

        if (vid_rd) begin
          if (model_pend) model_ovf[0] = 1'b1;
          model_pend      = 1'b1;
          model_pend_addr = vid_addr;
        end
        if (cpu_we && cpu_addr[15]) begin
          if (model_q.size() < DEPTH) model_q.push_back('{cpu_addr[12:0], cpu_addr[14:13], cpu_din});
          else model_ovf[1] = 1'b1;
        end
        checkOutput("cpu_full", 64'(cpu_full), 64'(model_q.size() == DEPTH));
        checkOutput("ovf", 64'(ovf), 64'(model_ovf));
      end
      prev_req   = sdr_bus.sdr_req;
      prev_we    = sdr_bus.sdr_we;
      prev_addr  = sdr_bus.sdr_addr;
      prev_be    = sdr_bus.sdr_be;
      prev_wdata = sdr_bus.sdr_wdata;
    end
  end

  // Directed scenarios first, then randomized traffic, then a bounded drain.
  initial begin
    int base_cnt;
    int req_seen;
    bit do_rd;
    int rd_age;
    reset    = 1'b1;
    vid_rd   = 1'b0;
    vid_addr = '0;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_din  = '0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    $display("[TB] single video read");
    ack_delay  = 2;
    next_rdata = 32'hDEADBEEF;
    applyStimulus(1'b1, 13'h0A5F, 1'b0, 16'h0, 8'h0);
    wait_any_req("rd1_req_timeout");
    checkOutput("rd1_addr", 64'(sdr_bus.sdr_addr), 64'(25'h100A5F));
    checkOutput("rd1_we", 64'(sdr_bus.sdr_we), 64'd0);
    wait_valid("rd1_valid_timeout");
    checkOutput("rd1_data", 64'(vid_data), 64'h0DEADBEEF);
    checkOutput("rd1_ovf", 64'(ovf), 64'd0);
    @(negedge clk_sys);
    checkOutput("rd1_pulse_width", 64'(vid_valid), 64'd0);
    checkOutput("rd1_data_hold", 64'(vid_data), 64'h0DEADBEEF);

    $display("[TB] single CPU write");
    base_cnt = wr_ack_count;
    applyStimulus(1'b0, 13'h0, 1'b1, 16'hC012, 8'h5A);
    wait_any_req("wr1_req_timeout");
    checkOutput("wr1_we", 64'(sdr_bus.sdr_we), 64'd1);
    checkOutput("wr1_addr", 64'(sdr_bus.sdr_addr), 64'(25'h100012));
    checkOutput("wr1_be", 64'(sdr_bus.sdr_be), 64'(4'b0100));
    checkOutput("wr1_wdata", 64'(sdr_bus.sdr_wdata), 64'h05A5A5A5A);
    wait_idle("wr1_drain", 60);
    checkOutput("wr1_count", 64'(wr_ack_count - base_cnt), 64'd1);
    applyStimulus(1'b0, 13'h0, 1'b1, 16'h4012, 8'h66);
    repeat (4) @(negedge clk_sys);
    checkOutput("ignored_write", 64'(sdr_bus.sdr_req), 64'd0);

    $display("[TB] FIFO fill with acks withheld");
    ack_hold = 1'b1;
    ack_delay = 1;
    base_cnt = wr_ack_count;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 13'h0, 1'b1, 16'h8000 | 16'((i % 4) << 13) | 16'(16'h40 + i), 8'(8'h10 + i));
      if (i == 2) checkOutput("fill_not_full", 64'(cpu_full), 64'd0);
      if (i == 3) checkOutput("fill_full", 64'(cpu_full), 64'd1);
    end
    checkOutput("fill_ovf_wr", 64'(ovf), 64'(2'b10));
    ack_hold = 1'b0;
    wait_idle("fill_drain", 100);
    checkOutput("fill_count", 64'(wr_ack_count - base_cnt), 64'd4);

    $display("[TB] read priority and overrun");
    applyStimulus(1'b1, 13'h0123, 1'b1, 16'h8456, 8'h9C);
    wait_any_req("prio_req_timeout");
    checkOutput("prio_first_is_read", 64'(sdr_bus.sdr_we), 64'd0);
    checkOutput("prio_rd_addr", 64'(sdr_bus.sdr_addr), 64'(25'h100123));
    wait_valid("prio_valid_timeout");
    @(negedge clk_sys);
    wait_any_req("prio_wr_timeout");
    checkOutput("prio_then_write", 64'(sdr_bus.sdr_we), 64'd1);
    checkOutput("prio_wr_addr", 64'(sdr_bus.sdr_addr), 64'(25'h100456));
    wait_idle("prio_drain", 60);
    ack_hold = 1'b1;
    applyStimulus(1'b0, 13'h0, 1'b1, 16'h8777, 8'h01);
    wait_any_req("ovr_wr_timeout");
    applyStimulus(1'b1, 13'h0AAA, 1'b0, 16'h0, 8'h0);
    applyStimulus(1'b1, 13'h1BBB, 1'b0, 16'h0, 8'h0);
    checkOutput("ovr_flag", 64'(ovf), 64'(2'b11));
    base_cnt = valid_count;
    ack_hold = 1'b0;
    wait_read_req("ovr_rd_timeout");
    checkOutput("ovr_latest_addr", 64'(sdr_bus.sdr_addr), 64'(25'h101BBB));
    wait_idle("ovr_drain", 60);
    checkOutput("ovr_one_read", 64'(valid_count - base_cnt), 64'd1);

    $display("[TB] read of a word with a queued write");
    ack_hold = 1'b1;
    applyStimulus(1'b0, 13'h0, 1'b1, 16'h8005, 8'hEE);
    wait_any_req("merge_wr_timeout");
    applyStimulus(1'b0, 13'h0, 1'b1, 16'hA003, 8'h77);
    applyStimulus(1'b1, 13'h0003, 1'b0, 16'h0, 8'h0);
    next_rdata = 32'h11223344;
    ack_hold   = 1'b0;
    wait_read_req("merge_rd_timeout");
    checkOutput("merge_rd_addr", 64'(sdr_bus.sdr_addr), 64'(25'h100003));
    wait_valid("merge_valid_timeout");
    checkOutput("merge_data", 64'(vid_data), MERGE_EN ? 64'h011227744 : 64'h011223344);
    wait_idle("merge_drain", 60);

    $display("[TB] reset during read");
    ack_hold = 1'b1;
    applyStimulus(1'b1, 13'h0042, 1'b1, 16'h8010, 8'h33);
    wait_any_req("rst_req_timeout");
    checkOutput("rst_in_read", 64'(sdr_bus.sdr_we), 64'd0);
    reset = 1'b1;
    @(negedge clk_sys);
    checkOutput("rst_req_drop", 64'(sdr_bus.sdr_req), 64'd0);
    checkOutput("rst_no_valid", 64'(vid_valid), 64'd0);
    reset    = 1'b0;
    ack_hold = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (sdr_bus.sdr_req === 1'b1 || vid_valid === 1'b1) req_seen++;
    end
    checkOutput("rst_fifo_empty", 64'(req_seen), 64'd0);

    $display("[TB] randomized traffic");
    ack_rand  = 1'b1;
    ack_delay = 1;
    rd_age    = 0;
    for (int c = 0; c < 1500; c++) begin
      do_rd = !rd_outstanding && ($urandom_range(0, 7) == 0);
      if (do_rd) begin
        rd_outstanding = 1'b1;
        rd_age         = 0;
      end
      applyStimulus(do_rd, 13'($urandom), $urandom_range(0, 2) == 0, 16'($urandom), 8'($urandom));
      if (rd_outstanding) begin
        rd_age++;
        if (rd_age > 200) begin
          checkOutput("rd_timeout", 64'(rd_age), 64'd0);
          rd_outstanding = 1'b0;
        end
      end
    end
    wait_idle("final_drain", 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
